eth_frame_mux_rr: RTL
=====================

Name: eth_frame_mux_rr

Overview:
- Parametrised N:1 frame multiplexer for the switch output path. Successor to the fixed 4:1 one-hot select mux.
- Instead of an externally supplied select, it arbitrates among NUM_PORTS valid/ready streams with round-robin fairness.
- It locks the grant for a whole frame (through the `last` beat) and drives a registered output stage toward the egress MAC/FIFO.

Parameters:
- NUM_PORTS, 4: number of input streams; must be >= 2.
- WIDTH, 8: data width of each stream beat.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_PORTS*WIDTH  packed input data; port i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_PORTS  per-port beat valid.
- in_last  input  NUM_PORTS  per-port end-of-frame marker, qualified by in_valid.
- in_ready  output  NUM_PORTS  per-port ready.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_last  output  1  registered end-of-frame marker.
- out_ready  input  1  downstream ready.
- grant  output  NUM_PORTS  one-hot current owner; all zero when idle.
- frame_done  output  1  one-cycle pulse when a last beat is accepted from the granted input.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, out_valid=0, out_last=0, out_data=0, frame_done=0, rr_ptr=0, in_ready=0.
- Handshake: a beat transfers on in_valid[i] && in_ready[i], or on out_valid && out_ready.
  - Once out_valid is asserted, out_data and out_last hold stable until accepted.
- States:
  - IDLE: if any in_valid is set, select the first requester at or after rr_ptr in ascending order with wrap (NUM_PORTS-1 -> 0). Register the one-hot grant and go to BUSY. Arbitration costs exactly one cycle: request at cycle t, grant visible at t+1, earliest in_ready at t+1. If no requests, stay in IDLE.
  - BUSY: in_ready[g] = grant[g] && (!out_valid || out_ready); all other in_ready are 0 (combinational from registered state).
    - On an accepted beat: out_data <= granted in_data slice, out_last <= in_last[g], out_valid <= 1. The output register refills in the same cycle it drains, so throughput is 1 beat/cycle inside a frame.
    - If out_ready is high with no new beat accepted: out_valid <= 0.
    - If the accepted beat has in_last=1: frame_done pulses in the next cycle (aligned with out_valid of that beat), grant <= 0, rr_ptr <= g+1 (wrapping), state <= IDLE.
- Inter-frame gap: at least one idle cycle on in_ready between frames; the output register may still be draining during it.
- Fairness: the port that just finished has the lowest priority in the next arbitration. With all ports always requesting, the grant order is 0,1,...,N-1,0,...
- Locking: a granted port keeps the grant across in_valid bubbles (in_valid=0 mid-frame). There is no timeout and no preemption.
- Request withdrawal: if the granted port's in_valid drops before any beat, the grant still holds until that port delivers a last beat.
- Input rules: in_last and in_data of non-granted ports are ignored. in_last is ignored when in_valid=0.
- Single-beat frame (first beat has last=1): returns to IDLE after one beat.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready=0. There is no data loss or duplication.
- Reset mid-frame: all state clears immediately; the partial frame is abandoned and the output is invalidated.
- rr_ptr width: clog2(NUM_PORTS); increments modulo NUM_PORTS.
- grant is always either one-hot or zero. This is an assertion in the bench.

Test Plan:
- Reset, then port 2 sends a 3-beat frame (0xA1,0xA2,0xA3 last) with out_ready=1.
  - grant=4'b0100 one cycle after the request.
  - out_data sequence A1,A2,A3 on consecutive cycles, out_last with A3.
  - frame_done pulse with A3; grant=0 afterwards.
- All 4 ports continuously request 2-beat frames tagged with the port number.
  - Output frames appear in order 0,1,2,3,0.
  - Exactly one idle in_ready cycle between frames.
- Port 1 frame in progress, then port 0 asserts in_valid mid-frame.
  - Port 1 keeps the grant until its last beat.
  - Port 0 is served next.
- out_ready toggles 1,0,0,1 during a 4-beat frame (0x10..0x13).
  - out_data holds stable while out_ready=0.
  - All 4 beats arrive exactly once, in order.
- Granted port inserts 2 in_valid=0 bubbles mid-frame.
  - grant holds and in_ready stays high.
  - Other ports' valid beats are never accepted.
- rst_n pulsed low mid-frame with out_valid=1.
  - out_valid, grant and frame_done are 0 immediately.
  - After release, the next request from port 3 is granted (rr_ptr=0 scan) with 1-cycle latency.

Source files
------------

// File: rtl/eth_frame_mux_rr.sv
// Round-robin N:1 frame multiplexer with whole-frame grant locking
// and a registered valid/ready output stage.
module eth_frame_mux_rr #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [NUM_PORTS-1:0]       in_last,
  output logic [NUM_PORTS-1:0]       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       frame_done
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 frame_done_q, frame_done_d;

  logic                 drain_ok;
  logic [NUM_PORTS-1:0] rdy;
  logic                 beat_acc;
  logic [WIDTH-1:0]     sel_data;
  logic                 sel_last;
  logic [PW-1:0]        g_idx;
  logic [NUM_PORTS-1:0] arb_grant;
  logic                 arb_found;
  logic [PW:0]          scan;

  // Output slot is free when empty or being drained this cycle.
  assign drain_ok = !out_valid_q || out_ready;
  assign rdy      = (state_q == BUSY && drain_ok) ? grant_q : '0;
  assign beat_acc = |(in_valid & rdy);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    g_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
        g_idx    = PW'(i);
      end
    end
  end

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    scan      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan >= (PW+1)'(NUM_PORTS))
        scan = scan - (PW+1)'(NUM_PORTS);
      if (!arb_found && in_valid[scan[PW-1:0]]) begin
        arb_found                 = 1'b1;
        arb_grant[scan[PW-1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;

    if (beat_acc) begin
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_grant;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (beat_acc && sel_last) begin
          frame_done_d = 1'b1;
          grant_d      = '0;
          rr_ptr_d     = (g_idx == PW'(NUM_PORTS-1)) ?
                         '0 : g_idx + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = rdy;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign grant      = grant_q;
  assign frame_done = frame_done_q;

endmodule
